// File: rtl/sgbm_pkg.sv
// sgbm_pkg: shared constants and types for the SGBM disparity back end.
//   DISP_NUM     number of disparity candidates per pixel
//   COST_W       width of one aggregated cost
//   DISP_W       disparity index width
//   INVALID_DISP disparity code emitted when a pixel fails the uniqueness test
//   wta_node_t   winner-take-all tree element {best, idx, second}
// Config macro: SGBM_WTA_UNIQUENESS_EN adds the second-best cost field to wta_node_t.
package sgbm_pkg;

  localparam int unsigned DISP_NUM = 96;
  localparam int unsigned COST_W   = 9;
  localparam int unsigned DISP_W   = 7;

  localparam logic [DISP_W-1:0] INVALID_DISP = 7'h7F;

  typedef struct packed {
    logic [COST_W-1:0] best;
    logic [DISP_W-1:0] idx;
`ifdef SGBM_WTA_UNIQUENESS_EN
    logic [COST_W-1:0] second;
`endif
  } wta_node_t;

  function automatic logic [COST_W-1:0] cost_min(input logic [COST_W-1:0] x,
                                                 input logic [COST_W-1:0] y);
    return (y < x) ? y : x;
  endfunction

endpackage

// File: rtl/sgbm_wta_merge.sv
// sgbm_wta_merge: one registered node of the winner-take-all comparator tree.
//   clk, rst  clock and asynchronous active-high reset
//   a_i       element covering the lower disparity indices
//   b_i       element covering the higher disparity indices
//   y_o       registered merge result
// Config macro: SGBM_WTA_UNIQUENESS_EN builds the second-best cost path.
module sgbm_wta_merge
  import sgbm_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  wta_node_t a_i,
  input  wta_node_t b_i,
  output wta_node_t y_o
);

  wta_node_t y_d, y_q;
  logic      b_wins;
`ifdef SGBM_WTA_UNIQUENESS_EN
  logic [COST_W-1:0] loser;
`endif

  always_comb begin
    y_d    = '0;
    // Strict compare: on a tie the lower-index side keeps the win.
    b_wins = b_i.best < a_i.best;
    y_d.best = b_wins ? b_i.best : a_i.best;
    y_d.idx  = b_wins ? b_i.idx  : a_i.idx;
`ifdef SGBM_WTA_UNIQUENESS_EN
    // Runner-up is either the losing best or one of the incoming runners-up.
    loser      = b_wins ? a_i.best : b_i.best;
    y_d.second = cost_min(loser, cost_min(a_i.second, b_i.second));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/sgbm_wta.sv
// sgbm_wta: winner-take-all disparity selector, one pixel per clock, 8-cycle latency.
//   clk, rst     clock and asynchronous active-high reset
//   cost_aggr    DISP_NUM packed costs, disparity d at [d*COST_W +: COST_W]
//   aggr_row/col coordinates of the incoming pixel
//   aggr_valid   input qualifier (no backpressure)
//   disp         arg-min disparity, or INVALID_DISP when rejected as not unique
//   disp_row/col coordinates aligned with disp
//   disp_valid   output qualifier
//   disp_unique  uniqueness test result
//   frame_done   pulse with the output of pixel (IMG_ROW-1, IMG_COL-1)
// Config macro: SGBM_WTA_UNIQUENESS_EN enables second-cost tracking and the uniqueness
// stage; without it the last stage is a plain delay and disp_unique reads 1 after reset.
module sgbm_wta
  import sgbm_pkg::*;
#(
  parameter int unsigned UNIQ_RATIO = 15,
  parameter int unsigned IMG_ROW    = 200,
  parameter int unsigned IMG_COL    = 400
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DISP_NUM*COST_W-1:0] cost_aggr,
  input  logic [9:0]                 aggr_row,
  input  logic [9:0]                 aggr_col,
  input  logic                       aggr_valid,
  output logic [DISP_W-1:0]          disp,
  output logic [9:0]                 disp_row,
  output logic [9:0]                 disp_col,
  output logic                       disp_valid,
  output logic                       disp_unique,
  output logic                       frame_done
);

  localparam int unsigned TreeLat = 7;

  // Tree levels: 96 -> 48 -> 24 -> 12 -> 6 -> 3 -> 2 -> 1
  wta_node_t lvl0 [DISP_NUM];
  wta_node_t lvl1 [48];
  wta_node_t lvl2 [24];
  wta_node_t lvl3 [12];
  wta_node_t lvl4 [6];
  wta_node_t lvl5 [3];
  wta_node_t lvl6_m, lvl6_p_q;
  wta_node_t lvl7;

  always_comb begin
    for (int d = 0; d < DISP_NUM; d++) begin
      lvl0[d]        = '0;
      lvl0[d].best   = cost_aggr[d*COST_W +: COST_W];
      lvl0[d].idx    = DISP_W'(d);
`ifdef SGBM_WTA_UNIQUENESS_EN
      lvl0[d].second = '1;
`endif
    end
  end

  for (genvar i = 0; i < 48; i++) begin : g_lvl1
    sgbm_wta_merge u_merge (.clk(clk), .rst(rst), .a_i(lvl0[2*i]), .b_i(lvl0[2*i+1]),
                            .y_o(lvl1[i]));
  end
  for (genvar i = 0; i < 24; i++) begin : g_lvl2
    sgbm_wta_merge u_merge (.clk(clk), .rst(rst), .a_i(lvl1[2*i]), .b_i(lvl1[2*i+1]),
                            .y_o(lvl2[i]));
  end
  for (genvar i = 0; i < 12; i++) begin : g_lvl3
    sgbm_wta_merge u_merge (.clk(clk), .rst(rst), .a_i(lvl2[2*i]), .b_i(lvl2[2*i+1]),
                            .y_o(lvl3[i]));
  end
  for (genvar i = 0; i < 6; i++) begin : g_lvl4
    sgbm_wta_merge u_merge (.clk(clk), .rst(rst), .a_i(lvl3[2*i]), .b_i(lvl3[2*i+1]),
                            .y_o(lvl4[i]));
  end
  for (genvar i = 0; i < 3; i++) begin : g_lvl5
    sgbm_wta_merge u_merge (.clk(clk), .rst(rst), .a_i(lvl4[2*i]), .b_i(lvl4[2*i+1]),
                            .y_o(lvl5[i]));
  end

  // 3 -> 2: merge the low pair, register the highest-index element unchanged.
  sgbm_wta_merge u_merge_lvl6 (.clk(clk), .rst(rst), .a_i(lvl5[0]), .b_i(lvl5[1]),
                               .y_o(lvl6_m));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl6_p_q <= '0;
    end else begin
      lvl6_p_q <= lvl5[2];
    end
  end

  sgbm_wta_merge u_merge_lvl7 (.clk(clk), .rst(rst), .a_i(lvl6_m), .b_i(lvl6_p_q),
                               .y_o(lvl7));

  // Side-band pipeline matched to the tree depth.
  logic [TreeLat-1:0] vld_q;
  logic [9:0]         row_q [TreeLat];
  logic [9:0]         col_q [TreeLat];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < TreeLat; i++) begin
        row_q[i] <= '0;
        col_q[i] <= '0;
      end
    end else begin
      vld_q    <= {vld_q[TreeLat-2:0], aggr_valid};
      row_q[0] <= aggr_row;
      col_q[0] <= aggr_col;
      for (int i = 1; i < TreeLat; i++) begin
        row_q[i] <= row_q[i-1];
        col_q[i] <= col_q[i-1];
      end
    end
  end

  // Output stage: uniqueness decision or pure delay.
  logic [DISP_W-1:0] disp_d;
  logic              unique_d;

`ifdef SGBM_WTA_UNIQUENESS_EN
  logic [16:0] second_scaled, best_scaled;

  assign second_scaled = 17'(lvl7.second) * 17'd100;
  assign best_scaled   = 17'(lvl7.best) * 17'(100 + UNIQ_RATIO);

  always_comb begin
    unique_d = second_scaled >= best_scaled;
    disp_d   = unique_d ? lvl7.idx : INVALID_DISP;
  end
`else
  always_comb begin
    unique_d = 1'b1;
    disp_d   = lvl7.idx;
  end
`endif

  logic [DISP_W-1:0] disp_q;
  logic [9:0]        disp_row_q, disp_col_q;
  logic              disp_valid_q, disp_unique_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q        <= '0;
      disp_row_q    <= '0;
      disp_col_q    <= '0;
      disp_valid_q  <= 1'b0;
      disp_unique_q <= 1'b0;
    end else begin
      disp_q        <= disp_d;
      disp_row_q    <= row_q[TreeLat-1];
      disp_col_q    <= col_q[TreeLat-1];
      disp_valid_q  <= vld_q[TreeLat-1];
      disp_unique_q <= unique_d;
    end
  end

  assign disp        = disp_q;
  assign disp_row    = disp_row_q;
  assign disp_col    = disp_col_q;
  assign disp_valid  = disp_valid_q;
  assign disp_unique = disp_unique_q;
  assign frame_done  = disp_valid_q && (disp_row_q == 10'(IMG_ROW - 1))
                       && (disp_col_q == 10'(IMG_COL - 1));

endmodule

// File: tb/tb_sgbm_wta.sv
// tb_sgbm_wta: self-checking bench for sgbm_wta against a behavioural arg-min model.
// Config macro: SGBM_WTA_UNIQUENESS_EN selects the expected uniqueness behaviour.
module tb_sgbm_wta;
  import sgbm_pkg::*;

  localparam int unsigned UNIQ = 15;
  localparam int unsigned ROWS = 200;
  localparam int unsigned COLS = 400;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [DISP_NUM*COST_W-1:0] cost_aggr = '0;
  logic [9:0]                 aggr_row = '0;
  logic [9:0]                 aggr_col = '0;
  logic                       aggr_valid = 1'b0;
  logic [DISP_W-1:0]          disp;
  logic [9:0]                 disp_row, disp_col;
  logic                       disp_valid, disp_unique, frame_done;

  sgbm_wta #(.UNIQ_RATIO(UNIQ), .IMG_ROW(ROWS), .IMG_COL(COLS)) dut (
    .clk(clk), .rst(rst), .cost_aggr(cost_aggr), .aggr_row(aggr_row),
    .aggr_col(aggr_col), .aggr_valid(aggr_valid), .disp(disp), .disp_row(disp_row),
    .disp_col(disp_col), .disp_valid(disp_valid), .disp_unique(disp_unique),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int costs [DISP_NUM];

  typedef struct {
    bit v;
    int d;
    bit u;
    int r;
    int c;
    bit fd;
  } exp_t;

  exp_t pipe_q[$];
  exp_t cur;

  // Reference: lowest-index minimum, second = smallest cost among the other candidates.
  function automatic void model(output int d, output bit u);
    int bi = 0;
    int best = costs[0];
    int second = 511;
    for (int i = 1; i < DISP_NUM; i++) if (costs[i] < best) begin best = costs[i]; bi = i; end
    for (int i = 0; i < DISP_NUM; i++) if (i != bi && costs[i] < second) second = costs[i];
`ifdef SGBM_WTA_UNIQUENESS_EN
    u = (second * 100 >= best * (100 + UNIQ));
    d = u ? bi : 127;
`else
    u = 1'b1;
    d = bi;
`endif
  endfunction

  // Empty model pipe: the first 7 cycles after reset show no pixel.
  task automatic flush_model();
    exp_t b;
    b = '{v: 1'b0, d: 0, u: 1'b0, r: 0, c: 0, fd: 1'b0};
    pipe_q.delete();
    for (int i = 0; i < 7; i++) pipe_q.push_back(b);
    cur = b;
  endtask

  // Drive one cycle; afterwards cur holds the expectation for the visible outputs.
  task automatic drive(input bit v, input int r, input int c);
    exp_t e;
    for (int i = 0; i < DISP_NUM; i++) cost_aggr[i*COST_W +: COST_W] = COST_W'(costs[i]);
    aggr_valid = v;
    aggr_row   = 10'(r);
    aggr_col   = 10'(c);
    e.v  = v;
    e.r  = r;
    e.c  = c;
    model(e.d, e.u);
    e.fd = v && (r == ROWS - 1) && (c == COLS - 1);
    pipe_q.push_back(e);
    @(posedge clk);
    #1;
    cur = pipe_q.pop_front();
  endtask

  task automatic fill_costs(input int v);
    for (int i = 0; i < DISP_NUM; i++) costs[i] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (disp !== '0) begin errors++; $display("FAIL reset_disp got %0h want 0", disp); end
    checks++; if (disp_row !== '0) begin errors++; $display("FAIL reset_row got %0d want 0", disp_row); end
    checks++; if (disp_col !== '0) begin errors++; $display("FAIL reset_col got %0d want 0", disp_col); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", disp_valid); end
    checks++; if (disp_unique !== 1'b0) begin errors++; $display("FAIL reset_unique got %0b want 0", disp_unique); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %0b want 0", frame_done); end
    rst = 1'b0;
    flush_model();
  endtask

  task automatic test_ramp();
    int seen_at = -1;
    for (int d = 0; d < DISP_NUM; d++) costs[d] = (d < 40) ? (40 - d) * 3 : (d - 40) * 3;
    for (int k = 1; k <= 12; k++) begin
      drive(k == 1, 12, 34);
      if (disp_valid === 1'b1) begin
        if (seen_at < 0) seen_at = k;
        checks++; if (disp !== 7'd40) begin errors++; $display("FAIL ramp_disp got %0d want 40", disp); end
        checks++; if (disp_unique !== 1'b1) begin errors++; $display("FAIL ramp_unique got %0b want 1", disp_unique); end
        checks++; if (disp_row !== 10'd12 || disp_col !== 10'd34) begin
          errors++; $display("FAIL ramp_coord got %0d,%0d want 12,34", disp_row, disp_col);
        end
      end
    end
    checks++; if (seen_at != 8) begin errors++; $display("FAIL ramp_latency got %0d want 8", seen_at); end
  endtask

  task automatic test_two_minima();
    int want_d;
    bit want_u;
`ifdef SGBM_WTA_UNIQUENESS_EN
    want_d = 127; want_u = 1'b0;
`else
    want_d = 17; want_u = 1'b1;
`endif
    fill_costs(100);
    costs[17] = 50;
    costs[63] = 50;
    for (int k = 1; k <= 8; k++) drive(k == 1, 3, 4);
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL tie_valid got %0b want 1", disp_valid); end
    checks++; if (disp !== 7'(want_d)) begin errors++; $display("FAIL tie_disp got %0d want %0d", disp, want_d); end
    checks++; if (disp_unique !== want_u) begin errors++; $display("FAIL tie_unique got %0b want %0b", disp_unique, want_u); end
  endtask

  task automatic test_uniq_boundary();
    int want_d [2];
    bit want_u [2];
`ifdef SGBM_WTA_UNIQUENESS_EN
    want_d = '{127, 30}; want_u = '{1'b0, 1'b1};
`else
    want_d = '{30, 30}; want_u = '{1'b1, 1'b1};
`endif
    fill_costs(511);
    for (int k = 1; k <= 10; k++) begin
      costs[30] = 100;
      costs[70] = (k == 1) ? 114 : 115;
      drive(k <= 2, 5, k);
      if (k >= 8 && k <= 9) begin
        checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL uniq_valid k=%0d got %0b want 1", k, disp_valid); end
        checks++; if (disp !== 7'(want_d[k-8])) begin
          errors++; $display("FAIL uniq_disp k=%0d got %0d want %0d", k, disp, want_d[k-8]);
        end
        checks++; if (disp_unique !== want_u[k-8]) begin
          errors++; $display("FAIL uniq_flag k=%0d got %0b want %0b", k, disp_unique, want_u[k-8]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    int run = 0;
    int best_run = 0;
    fill_costs(511);
    costs[95] = 0;
    for (int k = 0; k < 18; k++) begin
      drive(k < 10, k, 100 + k);
      checks++; if (disp_valid !== cur.v) begin errors++; $display("FAIL b2b_valid k=%0d got %0b want %0b", k, disp_valid, cur.v); end
      if (disp_valid === 1'b1) begin
        nvalid++; run++; if (run > best_run) best_run = run;
        checks++; if (disp !== 7'd95 || disp_unique !== 1'b1) begin
          errors++; $display("FAIL b2b_disp got %0d/%0b want 95/1", disp, disp_unique);
        end
        checks++; if (disp_row !== 10'(cur.r)) begin errors++; $display("FAIL b2b_order got %0d want %0d", disp_row, cur.r); end
      end else run = 0;
    end
    checks++; if (best_run != 10 || nvalid != 10) begin
      errors++; $display("FAIL b2b_count got %0d run %0d want 10", nvalid, best_run);
    end
  endtask

  task automatic test_frame_done();
    int rs [5] = '{199, 0, 199, 198, 199};
    int cs [5] = '{399, 0, 398, 399, 399};
    bit vs [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int pulses = 0;
    for (int k = 0; k < 13; k++) begin
      for (int i = 0; i < DISP_NUM; i++) costs[i] = $urandom_range(0, 511);
      if (k < 5) drive(vs[k], rs[k], cs[k]);
      else drive(1'b0, 0, 0);
      if (frame_done === 1'b1) pulses++;
      checks++; if (frame_done !== cur.fd) begin errors++; $display("FAIL frame_done k=%0d got %0b want %0b", k, frame_done, cur.fd); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL frame_done_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 68; k++) begin
      int mode = $urandom_range(0, 2);
      for (int i = 0; i < DISP_NUM; i++) begin
        if (mode == 0) costs[i] = $urandom_range(0, 15);
        else if (mode == 1) costs[i] = $urandom_range(0, 511);
        else costs[i] = $urandom_range(200, 511);
      end
      if (mode == 2) costs[$urandom_range(0, DISP_NUM - 1)] = $urandom_range(0, 220);
      drive((k < 60) && ($urandom_range(0, 3) != 0), $urandom_range(0, 1023), $urandom_range(0, 1023));
      checks++; if (disp_valid !== cur.v) begin errors++; $display("FAIL rand_valid k=%0d got %0b want %0b", k, disp_valid, cur.v); end
      if (cur.v) begin
        checks++; if (disp !== 7'(cur.d) || disp_unique !== cur.u) begin
          errors++; $display("FAIL rand_disp k=%0d got %0d/%0b want %0d/%0b", k, disp, disp_unique, cur.d, cur.u);
        end
        checks++; if (disp_row !== 10'(cur.r) || disp_col !== 10'(cur.c)) begin
          errors++; $display("FAIL rand_coord k=%0d got %0d,%0d want %0d,%0d", k, disp_row, disp_col, cur.r, cur.c);
        end
      end
      checks++; if (frame_done !== cur.fd) begin errors++; $display("FAIL rand_frame_done k=%0d got %0b want %0b", k, frame_done, cur.fd); end
    end
  endtask

  task automatic test_reset_midframe();
    int seen_at = -1;
    fill_costs(300);
    costs[9] = 7;
    for (int k = 0; k < 10; k++) drive(1'b1, 199, 390 + k);
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %0b want 1", disp_valid); end
    rst = 1'b1;
    #1;
    checks++; if (disp !== '0 || disp_row !== '0 || disp_col !== '0) begin
      errors++; $display("FAIL midrst_data got %0d %0d %0d want 0 0 0", disp, disp_row, disp_col);
    end
    checks++; if (disp_valid !== 1'b0 || disp_unique !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got %0b%0b%0b want 000", disp_valid, disp_unique, frame_done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    flush_model();
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, 199, 399);
      checks++; if (disp_valid !== 1'b0 || frame_done !== 1'b0) begin
        errors++; $display("FAIL midrst_ghost k=%0d got %0b/%0b want 0/0", k, disp_valid, frame_done);
      end
    end
    for (int k = 1; k <= 10; k++) begin
      drive(k == 1, 1, 2);
      if (disp_valid === 1'b1 && seen_at < 0) begin
        seen_at = k;
        checks++; if (disp !== 7'd9) begin errors++; $display("FAIL midrst_disp got %0d want 9", disp); end
      end
    end
    checks++; if (seen_at != 8) begin errors++; $display("FAIL midrst_latency got %0d want 8", seen_at); end
  endtask

  initial begin
    fill_costs(0);
    flush_model();
    #2;
    test_reset();
    test_ramp();
    test_two_minima();
    test_uniq_boundary();
    test_back_to_back();
    test_frame_done();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
